// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding, drain depth,
// architectural zero register and a helper for stage-enable decoding.
package pipeline_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_STEP   = ST_STEP,
    S_DRAIN  = ST_DRAIN,
    S_HALTED = ST_HALTED
  } state_t;

  localparam logic [1:0] DRAIN_DEPTH = 2'd3;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  function automatic logic pipe_active(input state_t s);
    return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard comparator: flags an ID-stage read of a register that the
// load currently in EX has not yet produced.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_pipe_en,
  input  logic       i_idex_memread,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  output logic       o_load_use
);

  // A load into r0 never creates a dependency.
  assign o_load_use = i_pipe_en && i_idex_memread && (i_idex_rt != REG_ZERO) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Debug-controlled pipeline sequencer with HALT drain and stall/flush steering.
// Optional active-cycle counter enabled by defining PIPE_CTRL_CYCLE_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic        i_step,
  input  logic        i_stop,
  input  logic        i_clear,
  input  logic        i_id_halt,
  input  logic        i_idex_memread,
  input  logic [4:0]  i_idex_rt,
  input  logic [4:0]  i_ifid_rs,
  input  logic [4:0]  i_ifid_rt,
  input  logic        i_ex_branch_taken,
  output logic        o_pipe_en,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble,
  output logic        o_halted,
  output logic [2:0]  o_state,
  output logic [31:0] o_cycle_cnt
);

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       halted_q, halted_d;
  logic       pipe_en, draining, flush, load_use, halt_ok;

  assign pipe_en  = pipe_active(state_q);
  assign draining = (state_q == S_DRAIN);
  assign flush    = pipe_en && i_ex_branch_taken;
  // A HALT seen while ID is stalled belongs to an instruction not yet valid.
  assign halt_ok  = i_id_halt && !load_use;

  hazard_detect u_hazard (
    .i_pipe_en      (pipe_en),
    .i_idex_memread (i_idex_memread),
    .i_idex_rt      (i_idex_rt),
    .i_ifid_rs      (i_ifid_rs),
    .i_ifid_rt      (i_ifid_rt),
    .o_load_use     (load_use)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_run)       state_d = S_RUN;
        else if (i_step) state_d = S_STEP;
      end
      S_STEP: begin
        if (halt_ok) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_DEPTH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_ok) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_DEPTH;
        end else if (i_stop) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Leave as the count reaches zero so DRAIN lasts exactly DRAIN_DEPTH cycles.
        if (drain_cnt_q <= 2'd1) begin
          state_d     = S_HALTED;
          drain_cnt_d = 2'd0;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      S_HALTED: begin
        if (i_clear) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        drain_cnt_d = 2'd0;
      end
    endcase
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Priority: drain freezes the front end, then flush, then load-use stall.
  always_comb begin
    o_pc_en       = pipe_en;
    o_ifid_en     = pipe_en;
    o_ifid_flush  = flush;
    o_idex_bubble = 1'b0;
    if (draining) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_bubble = 1'b1;
    end else if (flush) begin
      o_idex_bubble = 1'b1;
    end else if (load_use) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_bubble = 1'b1;
    end
  end

  assign o_pipe_en = pipe_en;
  assign o_halted  = halted_q;
  assign o_state   = state_q;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (i_clear)
      cycle_cnt_d = 32'd0;
    else if (pipe_en && (cycle_cnt_q != 32'hFFFF_FFFF))
      cycle_cnt_d = cycle_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cycle_cnt_q <= 32'd0;
    else          cycle_cnt_q <= cycle_cnt_d;
  end

  assign o_cycle_cnt = cycle_cnt_q;
`else
  assign o_cycle_cnt = 32'd0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and one reset: i_clk is the single clock, rising edge; i_rst_n is the reset, asynchronous and active-low.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_run  in  1  debug command: free-run (level-sampled)
- i_step  in  1  debug command: advance one cycle (single-cycle pulse)
- i_stop  in  1  debug command: return to idle (pulse)
- i_clear  in  1  leave HALTED, clear counters (pulse)
- i_id_halt  in  1  decoder flags HALT opcode in ID
- i_idex_memread  in  1  EX-stage instruction is a load
- i_idex_rt  in  5  EX-stage load destination
- i_ifid_rs  in  5  ID-stage rs
- i_ifid_rt  in  5  ID-stage rt
- i_ex_branch_taken  in  1  branch/jump resolved taken in EX
- o_pipe_en  out  1  global stage-register enable
- o_pc_en  out  1  PC write enable
- o_ifid_en  out  1  IF/ID write enable
- o_ifid_flush  out  1  zero IF/ID on next edge
- o_idex_bubble  out  1  insert NOP into ID/EX
- o_halted  out  1  program finished
- o_state  out  3  FSM state encoding, for the debug unit
- o_cycle_cnt  out  32  active-cycle count

Function
REQ-003 The FSM SHALL have states IDLE=0, RUN=1, STEP=2, DRAIN=3 and HALTED=4.
REQ-004 IDLE SHALL move to RUN on i_run and to STEP on i_step; if both are high, RUN wins.
REQ-005 STEP SHALL last exactly one cycle and then return to IDLE, unless i_id_halt is high, in which case it goes to DRAIN.
REQ-006 RUN SHALL move to IDLE on i_stop and to DRAIN on i_id_halt; if both are high, DRAIN wins.
REQ-007 On entry to DRAIN, a 2-bit drain counter SHALL load 3 and then decrement every cycle; at 0 the FSM moves to HALTED; i_stop is ignored in DRAIN.
REQ-008 HALTED SHALL hold until i_clear, then go to IDLE; all other commands are ignored in HALTED.
REQ-009 o_pipe_en SHALL be 1 in RUN, STEP and DRAIN, and 0 in IDLE and HALTED.
REQ-010 In DRAIN, o_pc_en and o_ifid_en SHALL be 0 and o_idex_bubble SHALL be 1 (nothing new enters the pipe).
REQ-011 Load-use hazard SHALL be defined as pipe_en && i_idex_memread && i_idex_rt!=0 && (i_idex_rt==i_ifid_rs || i_idex_rt==i_ifid_rt).
REQ-012 On a load-use hazard, o_pc_en=0, o_ifid_en=0 and o_idex_bubble=1 SHALL hold for that cycle.
REQ-013 When pipe_en && i_ex_branch_taken, o_ifid_flush=1 and o_idex_bubble=1 SHALL be driven; flush has priority over stall, so o_pc_en=1 and o_ifid_en=1.
REQ-014 Outside hazard, flush and DRAIN conditions, o_pc_en and o_ifid_en SHALL equal o_pipe_en; all hazard and flush outputs are combinational from state and inputs.
REQ-015 o_halted SHALL be 1 only in HALTED, and SHALL be registered (no combinational path from inputs).
REQ-016 A rising i_id_halt during a load-use stall SHALL be ignored (the stalled ID instruction is not yet valid).

Reset
REQ-017 Asserting i_rst_n low at any time, including mid-DRAIN, SHALL immediately give: state IDLE, drain counter 0, o_cycle_cnt 0, o_halted 0.
REQ-018 While reset is asserted, o_pipe_en, o_pc_en, o_ifid_en, o_ifid_flush and o_idex_bubble SHALL all be 0.
REQ-019 i_clear SHALL also zero o_cycle_cnt.

Configuration
REQ-020 PIPE_CTRL_CYCLE_CNT_EN SHALL be the only compile-time option.
- Defined: o_cycle_cnt increments on every cycle with o_pipe_en=1 and saturates at 0xFFFFFFFF.
- Undefined: no counter register is built and o_cycle_cnt is tied to 0.

Structure
REQ-021 The shared package SHALL hold the state encoding localparams, the drain depth constant (3) and the register-zero constant.
REQ-022 The hazard comparator SHALL be a sub-module, hazard_detect, that outputs only the load-use flag; the FSM, drain counter and cycle counter stay in pipeline_ctrl.

Verification
REQ-023 Release reset, pulse i_step once -> o_pipe_en high for exactly 1 cycle, then state=0 and o_cycle_cnt=1.
REQ-024 In RUN, set i_idex_memread=1, i_idex_rt=5, i_ifid_rs=5 -> o_pc_en=0, o_ifid_en=0, o_idex_bubble=1; with i_idex_rt=0 -> no stall.
REQ-025 In RUN, assert the REQ-024 stall and i_ex_branch_taken in the same cycle -> o_ifid_flush=1, o_pc_en=1, o_idex_bubble=1.
REQ-026 In RUN, pulse i_id_halt -> 3 DRAIN cycles with o_pc_en=0, then o_halted=1; i_run is then ignored; i_clear -> IDLE with o_cycle_cnt=0.
REQ-027 Pull i_rst_n low during the second DRAIN cycle -> all outputs 0 and state=0 before the next clock edge.
REQ-028 With PIPE_CTRL_CYCLE_CNT_EN defined, force the counter to 0xFFFFFFFE and run 3 cycles -> it reads 0xFFFFFFFF; with the macro undefined -> it reads 0.
